// File: rtl/dwc_rsp0_if.sv
// Response-path width converter bundle: wide producer side plus narrow sink side.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both sides; the converter holds the slave view.
//
// Ports carried:
//   dwc_rsp_valid/ready/rdata          wide word from the producer into the converter
//   fifo_rsp_valid/ready/rdata/last    narrow beats from the converter into the sink
interface dwc_rsp0_if #(
   parameter int IN_W  = 128,
   parameter int OUT_W = 32
);
   logic              dwc_rsp_valid;
   logic              dwc_rsp_ready;
   logic [IN_W-1:0]   dwc_rsp_rdata;
   logic              fifo_rsp_valid;
   logic              fifo_rsp_ready;
   logic [OUT_W-1:0]  fifo_rsp_rdata;
   logic              fifo_rsp_last;

   // Environment view: drives the wide word and the sink ready.
   modport master (
      output dwc_rsp_valid,
      output dwc_rsp_rdata,
      input  dwc_rsp_ready,
      input  fifo_rsp_valid,
      input  fifo_rsp_rdata,
      input  fifo_rsp_last,
      output fifo_rsp_ready
   );

   // Converter view.
   modport slave (
      input  dwc_rsp_valid,
      input  dwc_rsp_rdata,
      output dwc_rsp_ready,
      output fifo_rsp_valid,
      output fifo_rsp_rdata,
      output fifo_rsp_last,
      input  fifo_rsp_ready
   );
endinterface

// File: rtl/dwc_rsp0.sv
// Downsizing response converter: one wide word in, RSP_WORD_NUMBER narrow beats out, last beat flagged.
// Latency: first beat one cycle after the wide word is accepted; 1 beat/cycle sustained, no bubble between words.
// Backpressure: sink stall freezes the current beat; a new wide word is only taken on the last-beat handshake.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    dwc_rsp0_if.slave (wide valid/ready/rdata in, narrow valid/ready/rdata/last out)
module dwc_rsp0 #(
   parameter int INPUT_DATA_WIDTH  = 128,
   parameter int OUTPUT_DATA_WIDTH = 32,
   parameter int RSP_WORD_NUMBER   = INPUT_DATA_WIDTH / OUTPUT_DATA_WIDTH,
   parameter bit LSB_FIRST         = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   dwc_rsp0_if.slave  bus
);

   // ------------------------------------------------------------------
   // Parameter sanity
   // ------------------------------------------------------------------
   generate
      if (INPUT_DATA_WIDTH != RSP_WORD_NUMBER * OUTPUT_DATA_WIDTH) begin : g_bad_ratio
         $error("dwc_rsp0: INPUT_DATA_WIDTH must equal RSP_WORD_NUMBER*OUTPUT_DATA_WIDTH");
      end
      if (RSP_WORD_NUMBER < 2) begin : g_bad_count
         $error("dwc_rsp0: RSP_WORD_NUMBER must be at least 2");
      end
      if ($bits(bus.dwc_rsp_rdata) != INPUT_DATA_WIDTH) begin : g_bad_in_w
         $error("dwc_rsp0: interface wide data width does not match INPUT_DATA_WIDTH");
      end
      if ($bits(bus.fifo_rsp_rdata) != OUTPUT_DATA_WIDTH) begin : g_bad_out_w
         $error("dwc_rsp0: interface narrow data width does not match OUTPUT_DATA_WIDTH");
      end
   endgenerate

   localparam int            CW       = $clog2(RSP_WORD_NUMBER);
   localparam logic [CW-1:0] LAST_IDX = CW'(RSP_WORD_NUMBER - 1);

   typedef enum logic {
      IDLE = 1'b0,   // nothing held, wide side ready
      SEND = 1'b1    // word held, cnt_q is the beat on the narrow side
   } state_t;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t                        state_q, state_d;
   logic [CW-1:0]                 cnt_q,   cnt_d;
   logic [INPUT_DATA_WIDTH-1:0]   hold_q,  hold_d;

   // Combinational handshake terms
   logic                          out_vld;
   logic                          out_last;
   logic                          beat_hs;
   logic                          in_rdy;
   logic                          in_acc;
   logic [CW-1:0]                 beat_idx;
   logic [OUTPUT_DATA_WIDTH-1:0]  beat_dat;

   // ------------------------------------------------------------------
   // Output side decode
   // ------------------------------------------------------------------
   always_comb begin
      out_vld  = (state_q == SEND);
      out_last = out_vld && (cnt_q == LAST_IDX);
      beat_hs  = out_vld && bus.fifo_rsp_ready;

      // The wide side is refilled either from empty or on the very edge the
      // last beat leaves, which is what keeps back-to-back words bubble-free.
      // Held low through reset so nothing is taken while the block is cleared.
      in_rdy   = rst_n && ((state_q == IDLE) || (out_last && bus.fifo_rsp_ready));
      in_acc   = bus.dwc_rsp_valid && in_rdy;
   end

   // Beat ordering: LSB_FIRST walks slices upward, otherwise downward from the top slice.
   always_comb begin
      beat_idx = LSB_FIRST ? cnt_q : (LAST_IDX - cnt_q);
   end

   // Explicit slice mux; the held word is zero after reset so the narrow
   // data reads zero until the first word is loaded.
   always_comb begin
      beat_dat = '0;
      for (int i = 0; i < RSP_WORD_NUMBER; i++) begin
         if (beat_idx == CW'(i)) begin
            beat_dat = hold_q[i*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH];
         end
      end
   end

   // ------------------------------------------------------------------
   // Next-state
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;

      unique case (state_q)
         IDLE: begin
            if (in_acc) begin
               hold_d  = bus.dwc_rsp_rdata;
               cnt_d   = '0;
               state_d = SEND;
            end
         end

         SEND: begin
            if (beat_hs) begin
               if (out_last) begin
                  if (in_acc) begin
                     // Reload on the last-beat edge and stay in SEND.
                     hold_d  = bus.dwc_rsp_rdata;
                     cnt_d   = '0;
                     state_d = SEND;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  // Counter only advances below LAST_IDX; it never wraps on its own.
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign bus.dwc_rsp_ready  = in_rdy;
   assign bus.fifo_rsp_valid = out_vld;
   assign bus.fifo_rsp_last  = out_last;
   assign bus.fifo_rsp_rdata = beat_dat;

endmodule
